// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: cpu6502 address/data/rw/phi2
// plus the read-data return path into the top-level idata mux.
interface irq_ctrl_if;
    logic        clk2;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic [7:0]  rdata;
    logic        rd_sel;

    modport master (output clk2, addr, wdata, rw, input  rdata, rd_sel);
    modport slave  (input  clk2, addr, wdata, rw, output rdata, rd_sel);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller for cpu6502: synchronises NSRC maskable sources
// and one edge-triggered NMI source into pending bits that drive active-low irq/nmi.
module irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'h4000
) (
    input  logic            clk,
    input  logic            reset_n,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_src,
    output logic            irq,
    output logic            nmi
);

    logic            clk2_d;
    logic            sel;
    logic            we;
    logic [1:0]      ofs;

    logic [NSRC-1:0] src_s1, src_s2, src_s3;
    logic [NSRC-1:0] pending, enable, mode;
    logic [NSRC-1:0] src_set, sts_clr;

    logic            nmi_s1, nmi_s2, nmi_s3;
    logic            nmi_en, nmi_pend;
    logic            nmi_set, nmi_clr;

    function automatic logic [7:0] ext8(input logic [NSRC-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NSRC-1:0] = v;
        return r;
    endfunction

    assign sel = (bus.addr[15:2] == BASE_ADDR[15:2]);
    assign ofs = bus.addr[1:0];
    // One strobe per bus write: rising phi2 seen against its registered copy.
    assign we  = bus.clk2 & ~clk2_d & ~bus.rw & sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk2_d <= 1'b0;
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_s3 <= 1'b0;
        end else begin
            clk2_d <= bus.clk2;
            src_s1 <= src;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
            nmi_s1 <= nmi_src;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    assign src_set = (mode & src_s2 & ~src_s3) | (~mode & src_s2);
    assign sts_clr = (we && ofs == 2'd0) ? bus.wdata[NSRC-1:0] : '0;
    assign nmi_set = nmi_s2 & ~nmi_s3;
    assign nmi_clr = we && (ofs == 2'd3) && bus.wdata[7];

    // Clear is applied before set so a same-cycle set always survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            nmi_en   <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            pending  <= (pending & ~sts_clr) | src_set;
            nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_set;
            if (we && ofs == 2'd1) enable <= bus.wdata[NSRC-1:0];
            if (we && ofs == 2'd2) mode   <= bus.wdata[NSRC-1:0];
            if (we && ofs == 2'd3) nmi_en <= bus.wdata[0];
        end
    end

    assign bus.rd_sel = sel & bus.rw;

    always_comb begin
        bus.rdata = 8'h00;
        if (bus.rd_sel) begin
            case (ofs)
                2'd0:    bus.rdata = ext8(pending);
                2'd1:    bus.rdata = ext8(enable);
                2'd2:    bus.rdata = ext8(mode);
                default: bus.rdata = {nmi_pend, 6'b000000, nmi_en};
            endcase
        end
    end

    assign irq = ~|(pending & enable);
    assign nmi = ~(nmi_pend & nmi_en);

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued as each stimulus is applied
// and popped against the DUT outputs once they have settled between clock edges.
module tb_irq_ctrl;
    localparam logic [15:0] BASE = 16'h4000;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] src;
    logic       nmi_src;
    logic       irq;
    logic       nmi;

    sb_t sbq[$];
    int  vectors     = 0;
    int  miscompares = 0;

    irq_ctrl_if bif ();

    irq_ctrl #(.NSRC(8), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave),
        .src     (src),
        .nmi_src (nmi_src),
        .irq     (irq),
        .nmi     (nmi)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, want %02h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic exp_rd(input string tag, input logic [1:0] ofs, input logic [7:0] exp);
        bif.addr = BASE + 16'(ofs);
        bif.rw   = 1'b1;
        push(tag, exp);
        #1;
        pop_chk(bif.rdata);
    endtask

    task automatic exp_pins(input string tag, input logic irq_e, input logic nmi_e);
        push(tag, {6'b0, irq_e, nmi_e});
        #1;
        pop_chk({6'b0, irq, nmi});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_drive(input logic [1:0] ofs, input logic [7:0] d);
        @(negedge clk);
        bif.addr  = BASE + 16'(ofs);
        bif.wdata = d;
        bif.rw    = 1'b0;
        bif.clk2  = 1'b1;
    endtask

    task automatic wr_end();
        @(negedge clk);
        bif.clk2 = 1'b0;
        bif.rw   = 1'b1;
        bif.addr = 16'h0000;
    endtask

    task automatic bus_write(input logic [1:0] ofs, input logic [7:0] d);
        wr_drive(ofs, d);
        wr_end();
    endtask

    initial begin
        reset_n   = 1'b1;
        src       = 8'h00;
        nmi_src   = 1'b0;
        bif.clk2  = 1'b0;
        bif.addr  = 16'h0000;
        bif.wdata = 8'h00;
        bif.rw    = 1'b1;
        #1 reset_n = 1'b0;

        // Reset defaults with sources toggling underneath
        tick(2);
        src = 8'hFF;
        tick(2);
        exp_pins("rst_pins", 1'b1, 1'b1);
        exp_rd("rst_status", 2'd0, 8'h00);
        exp_rd("rst_enable", 2'd1, 8'h00);
        exp_rd("rst_mode",   2'd2, 8'h00);
        exp_rd("rst_nmictl", 2'd3, 8'h00);
        bif.addr = BASE + 16'd4;
        push("rdsel_outside", 8'h00);
        #1 pop_chk({7'b0, bif.rd_sel});
        push("rdata_outside", 8'h00);
        #1 pop_chk(bif.rdata);
        bif.addr = BASE + 16'd1;
        push("rdsel_inside", 8'h01);
        #1 pop_chk({7'b0, bif.rd_sel});
        src = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        exp_rd("post_rst_status", 2'd0, 8'h00);

        // Edge-mode IRQ and its three-edge latency
        bus_write(2'd2, 8'h01);
        bus_write(2'd1, 8'h01);
        exp_rd("mode_rb",   2'd2, 8'h01);
        exp_rd("enable_rb", 2'd1, 8'h01);
        @(negedge clk); src = 8'h01;
        @(negedge clk); src = 8'h00;
        @(negedge clk);
        exp_rd("edge_pend_early", 2'd0, 8'h00);
        exp_pins("edge_irq_early", 1'b1, 1'b1);
        @(negedge clk);
        exp_rd("edge_pend", 2'd0, 8'h01);
        exp_pins("edge_irq", 1'b0, 1'b1);
        tick(3);
        exp_rd("edge_pend_held", 2'd0, 8'h01);
        wr_drive(2'd0, 8'h01);
        exp_pins("w1c_not_yet", 1'b0, 1'b1);
        push("rdsel_write", 8'h00);
        #1 pop_chk({7'b0, bif.rd_sel});
        wr_end();
        exp_pins("w1c_irq", 1'b1, 1'b1);
        exp_rd("w1c_status", 2'd0, 8'h00);

        // Level mode, masking, W1C while the source stays high
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h04);
        @(negedge clk); src = 8'h20;
        @(negedge clk); src = 8'h00;
        tick(3);
        exp_rd("masked_pend", 2'd0, 8'h20);
        exp_pins("masked_irq", 1'b1, 1'b1);
        bus_write(2'd0, 8'h20);
        src = 8'h04;
        tick(4);
        exp_rd("level_pend", 2'd0, 8'h04);
        exp_pins("level_irq", 1'b0, 1'b1);
        bus_write(2'd0, 8'h04);
        tick(1);
        exp_rd("level_w1c_held", 2'd0, 8'h04);
        exp_pins("level_irq_held", 1'b0, 1'b1);
        src = 8'h00;
        tick(4);
        bus_write(2'd0, 8'h04);
        exp_rd("level_cleared", 2'd0, 8'h00);
        exp_pins("level_irq_off", 1'b1, 1'b1);

        // Set and W1C colliding on the same edge
        bus_write(2'd2, 8'h01);
        bus_write(2'd1, 8'h01);
        @(negedge clk); src = 8'h01;
        @(negedge clk); src = 8'h00;
        wr_drive(2'd0, 8'h01);
        wr_end();
        exp_rd("collide_pend", 2'd0, 8'h01);
        exp_pins("collide_irq", 1'b0, 1'b1);
        bus_write(2'd2, 8'h00);
        exp_rd("mode_change_keeps", 2'd0, 8'h01);
        bus_write(2'd0, 8'h01);
        exp_rd("collide_cleared", 2'd0, 8'h00);

        // NMI pending, enable, merge and clear
        @(negedge clk); nmi_src = 1'b1;
        tick(3);
        exp_rd("nmi_pend_noen", 2'd3, 8'h80);
        exp_pins("nmi_noen", 1'b1, 1'b1);
        bus_write(2'd3, 8'h01);
        exp_pins("nmi_en_low", 1'b1, 1'b0);
        exp_rd("nmictl_81", 2'd3, 8'h81);
        nmi_src = 1'b0;
        tick(3);
        nmi_src = 1'b1;
        tick(4);
        exp_pins("nmi_merged", 1'b1, 1'b0);
        exp_rd("nmictl_merged", 2'd3, 8'h81);
        bus_write(2'd3, 8'h81);
        exp_pins("nmi_cleared", 1'b1, 1'b1);
        exp_rd("nmictl_01", 2'd3, 8'h01);
        bus_write(2'd3, 8'h7F);
        exp_rd("nmictl_unused", 2'd3, 8'h01);

        // Asynchronous reset mid-write with both outputs asserted
        bus_write(2'd1, 8'h01);
        src = 8'h01;
        nmi_src = 1'b0;
        tick(3);
        nmi_src = 1'b1;
        tick(4);
        exp_pins("pre_rst_pins", 1'b0, 1'b0);
        wr_drive(2'd1, 8'hFF);
        #2 reset_n = 1'b0;
        exp_pins("async_rst_pins", 1'b1, 1'b1);
        @(negedge clk);
        bif.clk2 = 1'b0;
        bif.rw   = 1'b1;
        exp_rd("rst_mid_enable", 2'd1, 8'h00);
        exp_rd("rst_mid_status", 2'd0, 8'h00);
        @(negedge clk); reset_n = 1'b1;
        tick(3);
        exp_rd("release_edge_pend", 2'd0, 8'h01);
        exp_rd("release_nmi_pend",  2'd3, 8'h80);
        exp_pins("release_pins", 1'b1, 1'b1);

        if (sbq.size() != 0) chk("scoreboard_leftover", 8'(sbq.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
